// File: rtl/full_adder_pkg.sv
// Shared constants and a reference model for the ripple-carry full adder.
// fa_ref gives benches a width-aware golden result independent of the cell chain.
package full_adder_pkg;

    localparam int FA_WIDTH_DEFAULT = 1;
    localparam int FA_WIDTH_MAX     = 64;

    typedef enum logic {
        FA_OUT_COMB = 1'b0,
        FA_OUT_REG  = 1'b1
    } fa_out_mode_e;

    typedef struct packed {
        logic                    carry;
        logic [FA_WIDTH_MAX-1:0] sum;
    } fa_result_t;

    // Operands above bit width-1 are masked off so the carry lands at bit 'width'.
    function automatic logic [FA_WIDTH_MAX:0] fa_ref(
        input logic [FA_WIDTH_MAX-1:0] x,
        input logic [FA_WIDTH_MAX-1:0] y,
        input logic                    c,
        input int                      width
    );
        logic [FA_WIDTH_MAX:0] mask;
        logic [FA_WIDTH_MAX:0] xm;
        logic [FA_WIDTH_MAX:0] ym;
        mask = ({{FA_WIDTH_MAX{1'b0}}, 1'b1} << width) - {{FA_WIDTH_MAX{1'b0}}, 1'b1};
        xm   = {1'b0, x} & mask;
        ym   = {1'b0, y} & mask;
        return xm + ym + {{FA_WIDTH_MAX{1'b0}}, c};
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; the producer owns the operands, the adder owns the result.
// There is no valid/ready handshake: operands are consumed continuously (combinational) or every i_clk edge (registered).
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_y;
    logic             i_carry;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;

    modport master (
        output i_x,
        output i_y,
        output i_carry,
        input  o_sum,
        input  o_carry
    );

    modport slave (
        input  i_x,
        input  i_y,
        input  i_carry,
        output o_sum,
        output o_carry
    );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder cell; the top chains WIDTH of these into a ripple carry.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: {o_carry, o_sum} = i_x + i_y + i_carry.
// PIPE_OUT selects reset-gated combinational outputs or an async-cleared output register.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH    = FA_WIDTH_DEFAULT,
    parameter bit PIPE_OUT = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    full_adder_if.slave  bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign carry[0] = bus.i_carry;

    for (genvar k = 0; k < WIDTH; k++) begin : g_chain
        full_adder_cell u_cell (
            .a  (bus.i_x[k]),
            .b  (bus.i_y[k]),
            .ci (carry[k]),
            .s  (sum_d[k]),
            .co (carry[k+1])
        );
    end

    assign carry_d = carry[WIDTH];

    if (PIPE_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;

        // Async clear drops any in-flight result as soon as reset asserts.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        assign bus.o_sum   = sum_q;
        assign bus.o_carry = carry_q;
    end else begin : g_comb
        logic unused_clk;

        assign unused_clk  = i_clk;
        assign bus.o_sum   = i_rst_n ? sum_d : '0;
        assign bus.o_carry = i_rst_n ? carry_d : 1'b0;
    end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder across combinational and registered configurations.
// Drivers push expected results at the falling edge; the monitor pops them just after the rising edge.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #10 clk = ~clk;

    full_adder_if #(.WIDTH(1))  if1 ();
    full_adder_if #(.WIDTH(8))  if8c ();
    full_adder_if #(.WIDTH(8))  if8p ();
    full_adder_if #(.WIDTH(16)) if16c ();
    full_adder_if #(.WIDTH(16)) if16p ();

    full_adder #(.WIDTH(1), .PIPE_OUT(1'b0)) u_w1 (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if1)
    );
    full_adder #(.WIDTH(8), .PIPE_OUT(1'b0)) u_w8c (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if8c)
    );
    full_adder #(.WIDTH(8), .PIPE_OUT(1'b1)) u_w8p (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if8p)
    );
    full_adder #(.WIDTH(16), .PIPE_OUT(1'b0)) u_w16c (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if16c)
    );
    full_adder #(.WIDTH(16), .PIPE_OUT(1'b1)) u_w16p (
        .i_clk (clk), .i_rst_n (rst_n), .bus (if16p)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0]  exp1_q[$];
    logic [8:0]  exp8c_q[$];
    logic [8:0]  exp8p_q[$];
    logic [16:0] exp16c_q[$];
    logic [16:0] exp16p_q[$];

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(
        input logic [2:0]  v1,  input logic [1:0]  e1,
        input logic [7:0]  x8,  input logic [7:0]  y8,  input logic c8,  input logic [8:0]  e8,
        input logic [15:0] x16, input logic [15:0] y16, input logic c16, input logic [16:0] e16
    );
        {if1.i_x, if1.i_y, if1.i_carry} = v1;
        if8c.i_x  = x8;  if8c.i_y  = y8;  if8c.i_carry  = c8;
        if8p.i_x  = x8;  if8p.i_y  = y8;  if8p.i_carry  = c8;
        if16c.i_x = x16; if16c.i_y = y16; if16c.i_carry = c16;
        if16p.i_x = x16; if16p.i_y = y16; if16p.i_carry = c16;
        exp1_q.push_back(e1);
        exp8c_q.push_back(e8);
        exp8p_q.push_back(e8);
        exp16c_q.push_back(e16);
        exp16p_q.push_back(e16);
    endtask

    function automatic logic [16:0] out1();
        return {15'b0, if1.o_carry, if1.o_sum};
    endfunction
    function automatic logic [16:0] out8c();
        return {8'b0, if8c.o_carry, if8c.o_sum};
    endfunction
    function automatic logic [16:0] out8p();
        return {8'b0, if8p.o_carry, if8p.o_sum};
    endfunction
    function automatic logic [16:0] out16c();
        return {if16c.o_carry, if16c.o_sum};
    endfunction
    function automatic logic [16:0] out16p();
        return {if16p.o_carry, if16p.o_sum};
    endfunction

    // Monitor: registered results appear after the edge that sampled the operands
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp1_q.size() > 0)   check("w1_comb",  out1(),   {15'b0, exp1_q.pop_front()});
            if (exp8c_q.size() > 0)  check("w8_comb",  out8c(),  {8'b0, exp8c_q.pop_front()});
            if (exp8p_q.size() > 0)  check("w8_pipe",  out8p(),  {8'b0, exp8p_q.pop_front()});
            if (exp16c_q.size() > 0) check("w16_comb", out16c(), exp16c_q.pop_front());
            if (exp16p_q.size() > 0) check("w16_pipe", out16p(), exp16p_q.pop_front());
        end
    end

    logic [1:0]  tt_e1 [8];
    logic [7:0]  d8_x  [8];
    logic [7:0]  d8_y  [8];
    logic        d8_c  [8];
    logic [8:0]  d8_e  [8];
    logic [15:0] d16_x [8];
    logic [15:0] d16_y [8];
    logic        d16_c [8];
    logic [16:0] d16_e [8];

    initial begin
        logic [8:0]  prev8;
        logic [16:0] prev16;
        logic [2:0]  v1;
        logic [1:0]  e1;
        logic [7:0]  x8, y8;
        logic        c8, c16;
        logic [15:0] x16, y16;

        tt_e1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        d8_x  = '{8'hFF, 8'h80, 8'h00, 8'hFF, 8'h12, 8'h7F, 8'h01, 8'hAA};
        d8_y  = '{8'h00, 8'h80, 8'h00, 8'hFF, 8'h34, 8'h01, 8'hFE, 8'h55};
        d8_c  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
        d8_e  = '{9'h100, 9'h100, 9'h000, 9'h1FF, 9'h047, 9'h080, 9'h0FF, 9'h100};
        d16_x = '{16'hFFFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h00FF, 16'hABCD, 16'h5555, 16'h0F0F};
        d16_y = '{16'h0000, 16'h8000, 16'h4321, 16'hFFFF, 16'h0001, 16'h1111, 16'hAAAA, 16'hF0F0};
        d16_c = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        d16_e = '{17'h10000, 17'h10000, 17'h05555, 17'h1FFFF, 17'h00100, 17'h0BCDF, 17'h10000, 17'h0FFFF};

        // Reset held with all-ones operands: every output must still read zero
        rst_n = 1'b0;
        {if1.i_x, if1.i_y, if1.i_carry} = 3'b111;
        if8c.i_x  = 8'hFF;   if8c.i_y  = 8'hFF;   if8c.i_carry  = 1'b1;
        if8p.i_x  = 8'hFF;   if8p.i_y  = 8'hFF;   if8p.i_carry  = 1'b1;
        if16c.i_x = 16'hFFFF; if16c.i_y = 16'hFFFF; if16c.i_carry = 1'b1;
        if16p.i_x = 16'hFFFF; if16p.i_y = 16'hFFFF; if16p.i_carry = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_w1",   out1(),   17'h0);
        check("rst_w8c",  out8c(),  17'h0);
        check("rst_w8p",  out8p(),  17'h0);
        check("rst_w16c", out16c(), 17'h0);
        check("rst_w16p", out16p(), 17'h0);

        @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("release_w1",  out1(),   17'h00003);
        check("release_w8c", out8c(),  17'h001FF);
        check("release_w8p", out8p(),  17'h00000);

        // Directed table; each row also checks the registered outputs still hold the previous result
        prev8  = 9'h1FF;
        prev16 = 17'h1FFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(3'(i), tt_e1[i], d8_x[i], d8_y[i], d8_c[i], d8_e[i],
                  d16_x[i], d16_y[i], d16_c[i], d16_e[i]);
            #1;
            check("pipe8_hold",  out8p(),  {8'b0, prev8});
            check("pipe16_hold", out16p(), prev16);
            prev8  = d8_e[i];
            prev16 = d16_e[i];
        end

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v1  = 3'($urandom_range(0, 7));
            e1  = {1'b0, v1[2]} + {1'b0, v1[1]} + {1'b0, v1[0]};
            x8  = 8'($urandom);
            y8  = 8'($urandom);
            c8  = 1'($urandom_range(0, 1));
            x16 = 16'($urandom);
            y16 = 16'($urandom);
            c16 = 1'($urandom_range(0, 1));
            drive(v1, e1, x8, y8, c8, {1'b0, x8} + {1'b0, y8} + {8'b0, c8},
                  x16, y16, c16, {1'b0, x16} + {1'b0, y16} + {16'b0, c16});
        end

        // Reset pulse between edges: outputs drop at once, combinational ones return at release
        @(negedge clk);
        drive(3'b111, 2'b11, 8'h12, 8'h34, 1'b1, 9'h047,
              16'h1234, 16'h4321, 1'b0, 17'h05555);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_w1",   out1(),   17'h0);
        check("mid_rst_w8c",  out8c(),  17'h0);
        check("mid_rst_w8p",  out8p(),  17'h0);
        check("mid_rst_w16c", out16c(), 17'h0);
        check("mid_rst_w16p", out16p(), 17'h0);
        #2 rst_n = 1'b1;
        #1;
        check("mid_rel_w1",   out1(),   17'h00003);
        check("mid_rel_w8c",  out8c(),  17'h00047);
        check("mid_rel_w16c", out16c(), 17'h05555);
        check("mid_rel_w8p",  out8p(),  17'h0);
        check("mid_rel_w16p", out16p(), 17'h0);

        @(negedge clk);
        drive(3'b011, 2'b10, 8'hFF, 8'h00, 1'b1, 9'h100,
              16'h8000, 16'h8000, 1'b0, 17'h10000);
        @(negedge clk);
        drive(3'b100, 2'b01, 8'h80, 8'h80, 1'b0, 9'h100,
              16'hFFFF, 16'h0000, 1'b1, 17'h10000);

        repeat (3) @(negedge clk);
        if (exp1_q.size() + exp8c_q.size() + exp8p_q.size() + exp16c_q.size() + exp16p_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: scoreboard entries left unchecked");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
